// File: rtl/irq_aggregator.sv
// irq_aggregator: interrupt controller for up to 16 peripheral IRQ sources.
// Each source is synchronized and latched as pending, in edge or level mode.
// Pending bits are masked by ENABLE and combined into one CPU interrupt plus
// the index of the lowest-numbered active source (bit 0 has highest priority).
//
// Ports:
//   clk, reset_n    system clock, asynchronous active-low reset
//   address[2:0]    register select (word address)
//   chipselect      slave select
//   write_n         active-low write strobe
//   writedata[15:0] write data
//   irq_in          raw active-high source IRQs, possibly asynchronous
//   readdata[15:0]  registered read data, one cycle after the address
//   irq             combined interrupt (OR of pending & ENABLE)
//   irq_index[3:0]  lowest active source index, 0 when none
//
// Register map: 0 STATUS (RO), 1 PENDING (W1C), 2 ENABLE, 3 MODE (1 = edge),
// 4 FORCE (W1S, reads 0), 5 ACTIVE ({any, 11'b0, index}), 6-7 reserved.
module irq_aggregator #(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [15:0]        readdata,
    output logic               irq,
    output logic [3:0]         irq_index
);

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam int unsigned IW = 4;

    localparam logic [AW-1:0] ADDR_STATUS  = 3'd0;
    localparam logic [AW-1:0] ADDR_PENDING = 3'd1;
    localparam logic [AW-1:0] ADDR_ENABLE  = 3'd2;
    localparam logic [AW-1:0] ADDR_MODE    = 3'd3;
    localparam logic [AW-1:0] ADDR_FORCE   = 3'd4;
    localparam logic [AW-1:0] ADDR_ACTIVE  = 3'd5;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
    logic [NUM_IRQ-1:0] hist_q, hist_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [DW-1:0]      readdata_q, readdata_d;

    logic               wr_en;
    logic [NUM_IRQ-1:0] wr_bits;
    logic [NUM_IRQ-1:0] sync_lvl;
    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] clr_bits;
    logic [NUM_IRQ-1:0] force_bits;
    logic [NUM_IRQ-1:0] set_bits;
    logic [NUM_IRQ-1:0] active;
    logic               unused_wdata;

    // Upper writedata bits have no storage when fewer than 16 sources exist.
    assign unused_wdata = ^writedata;

    // Synchronizer chain and edge history.
    always_comb begin
        sync_d[0] = irq_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        sync_lvl = sync_q[SYNC_STAGES-1];
        hist_d   = sync_lvl;
        edge_det = sync_lvl & ~hist_q;
    end

    // Register writes and pending update; a set wins over a same-cycle clear.
    always_comb begin
        wr_en      = chipselect && !write_n;
        wr_bits    = writedata[NUM_IRQ-1:0];
        clr_bits   = (wr_en && address == ADDR_PENDING) ? wr_bits : '0;
        force_bits = (wr_en && address == ADDR_FORCE)   ? wr_bits : '0;
        set_bits   = (mode_q & edge_det) | (~mode_q & sync_lvl) | force_bits;
        pending_d  = (pending_q & ~clr_bits) | set_bits;
        enable_d   = (wr_en && address == ADDR_ENABLE) ? wr_bits : enable_q;
        mode_d     = (wr_en && address == ADDR_MODE)   ? wr_bits : mode_q;
    end

    // Masked interrupt and lowest-index priority encoder.
    always_comb begin
        active    = pending_q & enable_q;
        irq       = |active;
        irq_index = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                irq_index = IW'(i);
            end
        end
    end

    // Read mux, sampled every clock regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_STATUS:  readdata_d = DW'(sync_lvl);
            ADDR_PENDING: readdata_d = DW'(pending_q);
            ADDR_ENABLE:  readdata_d = DW'(enable_q);
            ADDR_MODE:    readdata_d = DW'(mode_q);
            ADDR_ACTIVE:  readdata_d = {irq, 11'b0, irq_index};
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            hist_q     <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            readdata_q <= '0;
        end else begin
            sync_q     <= sync_d;
            hist_q     <= hist_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_irq_aggregator.sv
// Testbench for irq_aggregator: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the register map.
module tb_irq_aggregator;

    localparam int unsigned NUM_IRQ     = 8;
    localparam int unsigned SYNC_STAGES = 2;

    logic               clk;
    logic               reset_n;
    logic [2:0]         address;
    logic               chipselect;
    logic               write_n;
    logic [15:0]        writedata;
    logic [NUM_IRQ-1:0] irq_in;
    logic [15:0]        readdata;
    logic               irq;
    logic [3:0]         irq_index;

    int n_checks = 0;
    int n_errors = 0;

    // Model: sampled irq_in history (index 0 = most recent edge), registers.
    logic [NUM_IRQ-1:0] m_smp [0:SYNC_STAGES];
    logic [NUM_IRQ-1:0] m_pend;
    logic [NUM_IRQ-1:0] m_en;
    logic [NUM_IRQ-1:0] m_mode;

    irq_aggregator #(
        .NUM_IRQ    (NUM_IRQ),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .irq_in    (irq_in),
        .readdata  (readdata),
        .irq       (irq),
        .irq_index (irq_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_index(input logic [15:0] act);
        for (int i = 0; i < 16; i++) begin
            if (act[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    function automatic logic [15:0] m_active();
        return 16'(m_pend & m_en);
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        logic [15:0] act;
        act = m_active();
        case (a)
            3'd0:    return 16'(m_smp[SYNC_STAGES-1]);
            3'd1:    return 16'(m_pend);
            3'd2:    return 16'(m_en);
            3'd3:    return 16'(m_mode);
            3'd5:    return (act != 0) ? (16'h8000 + 16'(m_index(act))) : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic m_clear();
        for (int k = 0; k <= SYNC_STAGES; k++) m_smp[k] = '0;
        m_pend = '0;
        m_en   = '0;
        m_mode = '0;
    endtask

    // Advance one clock: predict from the pre-edge state, then compare.
    task automatic step();
        logic [15:0]        exp_rd;
        logic [NUM_IRQ-1:0] s, h, wb, clr, setb;
        logic               wr;
        if (!reset_n) begin
            m_clear();
            exp_rd = 16'h0000;
        end else begin
            exp_rd = m_read(address);
            s      = m_smp[SYNC_STAGES-1];
            h      = m_smp[SYNC_STAGES];
            wr     = chipselect && !write_n;
            wb     = writedata[NUM_IRQ-1:0];
            clr    = (wr && address == 3'd1) ? wb : '0;
            setb   = (wr && address == 3'd4) ? wb : '0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (m_mode[i] ? (s[i] && !h[i]) : s[i]) setb[i] = 1'b1;
            end
            m_pend = (m_pend & ~clr) | setb;
            if (wr && address == 3'd2) m_en   = wb;
            if (wr && address == 3'd3) m_mode = wb;
            for (int k = SYNC_STAGES; k > 0; k--) m_smp[k] = m_smp[k-1];
            m_smp[0] = irq_in;
        end
        @(posedge clk);
        #1;
        check("readdata", 32'(readdata), 32'(exp_rd));
        check("irq", 32'(irq), 32'(m_active() != 0));
        check("irq_index", 32'(irq_index), 32'(m_index(m_active())));
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [15:0] v);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        step();
        chipselect = 1'b0;
        v = readdata;
    endtask

    // Asynchronous reset in mid-cycle, held across two edges.
    task automatic mid_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_readdata", 32'(readdata), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_index", 32'(irq_index), 32'h0);
        m_clear();
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] v;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        irq_in     = '0;
        m_clear();
        step();
        step();
        reset_n = 1'b1;

        // All registers read zero after reset.
        for (int a = 0; a < 8; a++) begin
            bus_rd(3'(a), v);
            check("reset_read", 32'(v), 32'h0);
        end
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_index", 32'(irq_index), 32'h0);

        // Level mode on bit 0: latency and clear-while-held.
        bus_wr(3'd3, 16'h0000);
        bus_wr(3'd2, 16'h0001);
        irq_in[0] = 1'b1;
        step();
        step();
        check("lvl_latency_lo", 32'(irq), 32'h0);
        step();
        check("lvl_latency_hi", 32'(irq), 32'h1);
        bus_wr(3'd1, 16'h0001);
        check("lvl_clear_held", 32'(irq), 32'h1);
        irq_in[0] = 1'b0;
        step();
        step();
        step();
        bus_wr(3'd1, 16'h0001);
        check("lvl_cleared", 32'(irq), 32'h0);

        // Edge mode on bit 2 with a 3-cycle pulse.
        bus_wr(3'd3, 16'h0004);
        bus_wr(3'd2, 16'h0004);
        irq_in[2] = 1'b1;
        step();
        step();
        step();
        irq_in[2] = 1'b0;
        step();
        step();
        step();
        bus_rd(3'd1, v);
        check("edge_pending", 32'(v), 32'h0004);
        bus_rd(3'd5, v);
        check("edge_active", 32'(v), 32'h8002);
        bus_wr(3'd1, 16'h0004);
        check("edge_cleared", 32'(irq), 32'h0);

        // Software force and priority order.
        bus_wr(3'd2, 16'h00FF);
        bus_wr(3'd4, 16'h0050);
        bus_rd(3'd1, v);
        check("force_pending", 32'(v), 32'h0050);
        check("force_index4", 32'(irq_index), 32'h4);
        bus_wr(3'd1, 16'h0010);
        check("force_index6", 32'(irq_index), 32'h6);
        bus_wr(3'd1, 16'h0040);
        check("force_irq_off", 32'(irq), 32'h0);
        bus_rd(3'd5, v);
        check("force_active0", 32'(v), 32'h0000);

        // Edge arriving together with a clear of the same bit.
        bus_wr(3'd3, 16'h0002);
        bus_wr(3'd2, 16'h0002);
        irq_in[1] = 1'b1;
        step();
        step();
        bus_wr(3'd1, 16'h0002);
        check("setclr_irq", 32'(irq), 32'h1);
        bus_rd(3'd1, v);
        check("setclr_pending", 32'(v), 32'h0002);
        irq_in[1] = 1'b0;
        step();
        step();
        step();
        bus_wr(3'd1, 16'h0002);
        check("setclr_cleared", 32'(irq), 32'h0);

        // Masking, unmasking and asynchronous reset.
        bus_wr(3'd2, 16'h0000);
        bus_wr(3'd4, 16'h0008);
        check("mask_irq", 32'(irq), 32'h0);
        check("mask_index", 32'(irq_index), 32'h0);
        bus_wr(3'd2, 16'h0008);
        check("unmask_irq", 32'(irq), 32'h1);
        check("unmask_index", 32'(irq_index), 32'h3);
        bus_rd(3'd2, v);
        check("unmask_enable", 32'(v), 32'h0008);
        mid_reset();

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 3) == 0) irq_in = NUM_IRQ'($urandom);
            address    = 3'($urandom);
            writedata  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'(1 << $urandom_range(0, 15));
            chipselect = ($urandom_range(0, 2) != 0);
            write_n    = ($urandom_range(0, 1) == 0);
            step();
            chipselect = 1'b0;
            write_n    = 1'b1;
            if ($urandom_range(0, 199) == 0) mid_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
